// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage RV32I pipeline.
// Strobes are combinational from state and inputs; state and counters are registered.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_resp,
  input  logic        dcache_req,
  input  logic        dcache_resp,
  input  logic        ex_redirect,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  output logic        pc_load,
  output logic        ifid_load,
  output logic        idex_load,
  output logic        exmem_load,
  output logic        memwb_load,
  output logic        ifid_rst,
  output logic        idex_rst,
  output logic        exmem_rst,
  output logic        memwb_rst,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic {RUN, DROP} state_t;

  state_t state;
  logic   mem_stall;
  logic   load_use;
  logic   redirect_take;

  assign mem_stall     = dcache_req & ~dcache_resp;
  assign load_use      = idex_mem_read & (idex_rd != '0) &
                         ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));
  assign redirect_take = ~mem_stall & ex_redirect;

  always_comb begin
    pc_load    = 1'b0;
    ifid_load  = 1'b0;
    idex_load  = 1'b0;
    exmem_load = 1'b0;
    memwb_load = 1'b0;
    ifid_rst   = 1'b0;
    idex_rst   = 1'b0;
    exmem_rst  = 1'b0;
    memwb_rst  = 1'b0;
    if (rst) begin
      ifid_rst  = 1'b1;
      idex_rst  = 1'b1;
      exmem_rst = 1'b1;
      memwb_rst = 1'b1;
    end else if (mem_stall) begin
      // whole pipeline frozen; a pending redirect waits in ID/EX
    end else if (ex_redirect) begin
      pc_load    = 1'b1;
      ifid_rst   = 1'b1;
      idex_rst   = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
    end else if (load_use) begin
      idex_rst   = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
    end else if (state == DROP || !icache_resp) begin
      // a word returning in DROP is wrong-path and is discarded by the bubble
      ifid_rst   = 1'b1;
      idex_load  = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
    end else begin
      pc_load    = 1'b1;
      ifid_load  = 1'b1;
      idex_load  = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_load)
        stall_count <= stall_count + 32'd1;
      if (redirect_take)
        flush_count <= flush_count + 32'd1;
      if (!mem_stall && (ex_redirect || state == DROP))
        state <= icache_resp ? RUN : DROP;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// randomized traffic, compared every cycle against a cause-based reference model.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst, icache_resp, dcache_req, dcache_resp, ex_redirect, idex_mem_read;
  logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
  logic        pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic        ifid_rst, idex_rst, exmem_rst, memwb_rst;
  logic [31:0] stall_count, flush_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // reference model state
  bit          m_drop  = 1'b0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .icache_resp(icache_resp), .dcache_req(dcache_req),
    .dcache_resp(dcache_resp), .ex_redirect(ex_redirect), .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
    .exmem_load(exmem_load), .memwb_load(memwb_load),
    .ifid_rst(ifid_rst), .idex_rst(idex_rst), .exmem_rst(exmem_rst), .memwb_rst(memwb_rst),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // strobe vector: {pc, ifid, idex, exmem, memwb loads, ifid, idex, exmem, memwb clears}
  localparam logic [8:0] S_RESET  = 9'b00000_1111;
  localparam logic [8:0] S_FROZEN = 9'b00000_0000;
  localparam logic [8:0] S_REDIR  = 9'b10011_1100;
  localparam logic [8:0] S_LDUSE  = 9'b00011_0100;
  localparam logic [8:0] S_BUBBLE = 9'b00111_1000;
  localparam logic [8:0] S_NORMAL = 9'b11111_0000;

  // One cycle: apply inputs, compare against the model mid-cycle, then advance the model.
  task automatic cyc(input bit r, input bit ic, input bit dq, input bit dr, input bit ex,
                     input bit mr, input logic [4:0] rd, input logic [4:0] s1,
                     input logic [4:0] s2);
    logic [8:0] exp_s;
    bit frozen, hazard, go_redirect;
    rst = r; icache_resp = ic; dcache_req = dq; dcache_resp = dr; ex_redirect = ex;
    idex_mem_read = mr; idex_rd = rd; ifid_rs1 = s1; ifid_rs2 = s2;
    frozen      = dq && !dr;
    hazard      = mr && rd != 0 && (rd == s1 || rd == s2);
    go_redirect = !r && !frozen && ex;
    if (r)                  exp_s = S_RESET;
    else if (frozen)        exp_s = S_FROZEN;
    else if (ex)            exp_s = S_REDIR;
    else if (hazard)        exp_s = S_LDUSE;
    else if (m_drop || !ic) exp_s = S_BUBBLE;
    else                    exp_s = S_NORMAL;
    #4;
    check("strobes", {23'd0, pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                      ifid_rst, idex_rst, exmem_rst, memwb_rst}, {23'd0, exp_s});
    check("stall_count", stall_count, m_stall);
    check("flush_count", flush_count, m_flush);
    @(posedge clk);
    if (r) begin
      m_drop = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_s[8]) m_stall++;
      if (go_redirect) m_flush++;
      // an outstanding wrong-path fetch is dropped until its response arrives
      if (!frozen && (ex || m_drop)) m_drop = !ic;
    end
    #1;
  endtask

  task automatic run(input int unsigned n, input bit ic);
    for (int unsigned i = 0; i < n; i++) cyc(0, ic, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    rst = 1'b1; icache_resp = 1'b0; dcache_req = 1'b0; dcache_resp = 1'b0;
    ex_redirect = 1'b0; idex_mem_read = 1'b0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // steady flow, then a load-use hit on rs2
    run(5, 1);
    cyc(0, 1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5);
    cyc(0, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd5);
    check("stall_after_ldu", stall_count, 32'd1);
    // rd = x0 never stalls
    cyc(0, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd3);

    // redirect held through a 3-cycle data miss with a load-use also pending
    for (int unsigned i = 0; i < 3; i++) cyc(0, 1, 1, 0, 1, 1, 5'd7, 5'd7, 5'd0);
    cyc(0, 1, 1, 1, 1, 1, 5'd7, 5'd7, 5'd0);
    check("flush_after_miss", flush_count, 32'd1);

    // redirect with fetch outstanding: DROP until response, then fresh fetch
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    run(2, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // reset in the middle of DROP, then a normal fetch
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic with small register numbers so hazards are frequent
    for (int unsigned i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) == 0), ($urandom_range(2) != 0), ($urandom_range(3) == 0),
          ($urandom_range(1) == 0), ($urandom_range(5) == 0), ($urandom_range(2) == 0),
          5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage RV32I pipeline. It drives the load and synchronous-reset strobes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It freezes stages on cache misses, inserts bubbles for load-use hazards and fetch misses, and squashes wrong-path instructions on EX-stage redirects, including a fetch response that was already in flight. Two performance counters record stall cycles and accepted redirects.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- icache_resp  in  1  instruction fetch completes this cycle
- dcache_req  in  1  MEM-stage instruction accesses memory
- dcache_resp  in  1  data access completes this cycle
- ex_redirect  in  1  EX stage resolved a taken branch/jump; PC mux selects target
- idex_mem_read  in  1  ID/EX instruction is a load
- idex_rd  in  5  ID/EX destination register
- ifid_rs1, ifid_rs2  in  5 each  IF/ID source registers
- pc_load  out  1  load PC register
- ifid_load, idex_load, exmem_load, memwb_load  out  1 each  stage register load
- ifid_rst, idex_rst, exmem_rst, memwb_rst  out  1 each  stage register clear (bubble)
- stall_count  out  32  cycles with pc_load=0 since reset
- flush_count  out  32  redirects accepted since reset

## Operation
- Outputs are combinational from state and inputs. State (RUN, DROP) and counters are registered.
- While rst is high:
  - all four *_rst = 1 and all loads = 0
  - next state RUN, both counters cleared to 0
- Derived terms:
  - mem_stall = dcache_req & ~dcache_resp
  - load_use = idex_mem_read & (idex_rd != 0) & (idex_rd == ifid_rs1 | idex_rd == ifid_rs2)
- Priority (first match wins): rst > mem_stall > ex_redirect > load_use > fetch miss.
- mem_stall:
  - all loads = 0, all *_rst = 0 (whole pipeline frozen)
  - a pending ex_redirect is held in ID/EX and accepted once the stall clears
  - state unchanged
- ex_redirect accepted:
  - pc_load = 1, ifid_rst = 1, idex_rst = 1, exmem_load = 1, memwb_load = 1
  - flush_count += 1
  - if icache_resp = 0 this cycle, the old fetch is still outstanding: next state DROP
- load_use:
  - pc_load = 0, ifid_load = 0, idex_rst = 1, exmem_load = 1, memwb_load = 1
- Fetch miss (RUN, icache_resp = 0):
  - pc_load = 0, ifid_rst = 1 (bubble), downstream loads = 1
- Normal (RUN, icache_resp = 1): all loads = 1, all *_rst = 0.
- DROP state:
  - pc_load = 0, ifid_rst = 1, downstream loads = 1 (ex_redirect/load_use rules still apply at their priority)
  - on icache_resp = 1, the returning wrong-path word is discarded and next state is RUN
  - PC already holds the redirect target, so the next fetch is correct
- Counters:
  - stall_count increments every non-reset cycle with pc_load = 0
  - both counters wrap modulo 2^32

## Timing
- Zero-cycle control latency: strobes are valid in the same cycle as their cause and take effect at the next rising edge.
- Load-use costs exactly 1 bubble cycle. On the following cycle ID/EX holds a bubble, so load_use is false.
- A redirect with the fetch complete costs 2 bubbles (IF/ID and ID/EX cleared).
- A redirect with the fetch outstanding additionally holds DROP until icache_resp, then issues a fresh fetch.
- A mem_stall of N cycles freezes all stages for exactly N cycles. A load_use present during the stall is evaluated only after it clears.
- Simultaneous ex_redirect and load_use: the redirect wins and load_use is ignored, since the instruction causing it is squashed.
- Reset mid-DROP returns to RUN and drops nothing afterward.

## Test plan
- Reset, then icache_resp = 1 every cycle, no hazards -> all loads = 1, all *_rst = 0, stall_count stays 0.
- idex_mem_read = 1, idex_rd = 5, ifid_rs2 = 5 -> one cycle with pc_load = 0, ifid_load = 0, idex_rst = 1; stall_count = 1.
- idex_rd = 0 with matching rs1 and load -> no stall.
- dcache_req = 1, dcache_resp = 0 for 3 cycles while ex_redirect = 1 -> all loads 0 for 3 cycles, then redirect accepted on cycle 4; flush_count = 1.
- ex_redirect with icache_resp = 0, then icache_resp on cycle +3 -> DROP for 3 cycles with ifid_rst = 1, wrong word discarded, RUN next, pc_load = 1 on the next resp.
- rst asserted during DROP -> all *_rst = 1, counters 0; after release a single icache_resp loads IF/ID normally.
